spi_master_mc: RTL

Parametrised multi-mode SPI master: runtime-selectable CPOL/CPHA and bit order, configurable word width and SCK divider, and NUM_CS one-hot active-low chip selects with guaranteed lead and lag times. It replaces the fixed 8-bit mode-1 master in the digitizer control path. It sits between the register/command logic (start/busy/new_data handshake) and the board-level ADC/DAC/PLL SPI slaves.

---
 rtl/spi_master_mc.sv | 108 ++++++++++
 1 files changed

// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-mode SPI master (CPOL/CPHA/bit order at runtime, one-hot active-low chip selects); define SPI_MASTER_LOOPBACK_EN to add a loopback input that feeds mosi to the receiver
module spi_master_mc #(
  parameter int DATA_W = 8,
  parameter int HALF_DIV = 2,
  parameter int NUM_CS = 4,
  parameter int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              mosi,
  output logic              sck,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              new_data
);
  localparam int HW = $clog2(HALF_DIV + 1);
  localparam int EW = $clog2(2 * DATA_W);
  localparam int SW = CS_W + 1;
  localparam logic [HW-1:0] H_LAST = HW'(HALF_DIV - 1);
  localparam logic [EW-1:0] E_LAST = EW'(2 * DATA_W - 1);
  localparam logic [SW-1:0] CS_LIM = SW'(NUM_CS);
  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;
  state_t state;
  logic [HW-1:0] hcnt;
  logic [EW-1:0] ecnt;
  logic [DATA_W-1:0] tx, rx, tx_next;
  logic cpha_r, lsb_r, rx_bit, tx_bit, h_end, lead;
  // receive source, next transmit bit, half-period end and edge polarity
  always_comb begin
`ifdef SPI_MASTER_LOOPBACK_EN
    rx_bit = loopback ? mosi : miso;
`else
    rx_bit = miso;
`endif
    tx_bit = lsb_r ? tx[0] : tx[DATA_W-1];
    tx_next = lsb_r ? tx >> 1 : tx << 1;
    h_end = hcnt == H_LAST;
    lead = !ecnt[0];
  end
  // transfer sequencer with registered SPI pins and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt <= '0;
      ecnt <= '0;
      tx <= '0;
      rx <= '0;
      cpha_r <= 1'b0;
      lsb_r <= 1'b0;
      sck <= 1'b0;
      mosi <= 1'b0;
      cs_n <= '1;
      busy <= 1'b0;
      data_out <= '0;
      new_data <= 1'b0;
    end else begin
      new_data <= 1'b0;
      hcnt <= (state == IDLE || h_end) ? '0 : hcnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= SETUP;
          busy <= 1'b1;
          cpha_r <= cpha;
          lsb_r <= lsb_first;
          sck <= cpol;
          ecnt <= '0;
          cs_n <= ({1'b0, cs_sel} < CS_LIM) ? ~(NUM_CS'(1) << cs_sel) : '1;
          mosi <= cpha ? mosi : (lsb_first ? data_in[0] : data_in[DATA_W-1]);
          tx <= cpha ? data_in : (lsb_first ? data_in >> 1 : data_in << 1);
        end
        SETUP: if (h_end) state <= TRANSFER;
        TRANSFER: if (h_end) begin
          sck <= ~sck;
          ecnt <= ecnt + 1'b1;
          if (lead == cpha_r && ecnt != E_LAST) begin
            mosi <= tx_bit;
            tx <= tx_next;
          end
          if (lead != cpha_r)
            rx <= lsb_r ? {rx_bit, rx[DATA_W-1:1]} : {rx[DATA_W-2:0], rx_bit};
          if (ecnt == E_LAST) begin
            state <= HOLD;
            ecnt <= '0;
          end
        end
        HOLD: if (h_end) begin
          state <= IDLE;
          busy <= 1'b0;
          cs_n <= '1;
          data_out <= rx;
          new_data <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
